// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the mac_rx frame buffer
//
// Holds the write-side FSM state enum, the stored entry layout and the
// statistics counter width, plus a saturating-increment helper for the
// optional counters. No ports.
package mac_pkg;

   // Beat width of the mac_rx stream; the entry layout below is tied to it.
   localparam int MAC_DATA_W = 16;
   localparam int MAC_KEEP_W = MAC_DATA_W / 8;

   // Width of the optional per-frame statistics counters.
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECV    = 2'd1,
      ST_DISCARD = 2'd2
   } wr_state_e;

   // One buffer entry; packed MSB-first as {data, keep, last}.
   typedef struct packed {
      logic [MAC_DATA_W-1:0] data;
      logic [MAC_KEEP_W-1:0] keep;
      logic                  last;
   } entry_t;

   // Counter increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/mac_rx_frame_ram.sv
// rtl/mac_rx_frame_ram.sv - flop-array storage for the frame buffer
//
// DEPTH x WIDTH register array, synchronous write, asynchronous read.
// Ports:
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  combinational read data at rd_addr
module mac_rx_frame_ram #(
   parameter int DEPTH  = 64,
   parameter int WIDTH  = 19,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // No reset: contents are only ever observed between rd_ptr and commit_ptr.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_rx_frame_fifo.sv
// rtl/mac_rx_frame_fifo.sv - store-and-forward frame buffer behind mac_rx
//
// Holds each received frame until it ends with a good CRC, then releases it
// on a ready/valid stream with a last marker. CRC-failed, cancelled and
// oversized frames are discarded whole. Optional statistics counters are
// enabled by defining MAC_RX_FRAME_FIFO_STATS_EN.
// Ports:
//   clk, nreset              clock, asynchronous active-low reset
//   cancel_i                 abort the in-flight frame
//   valid_i, data_i, keep_i  incoming beat stream (valid contiguous per frame)
//   crc_err_i                CRC verdict, looked at in the end cycle only
//   ready_i                  downstream ready
//   valid_o, data_o, keep_o, last_o  outgoing beat stream
//   drop_o                   one-cycle pulse per discarded frame
//   good_cnt_o, crc_drop_cnt_o, cancel_drop_cnt_o, ovf_drop_cnt_o
//                            saturating frame counters (stats build only)
module mac_rx_frame_fifo
   import mac_pkg::*;
#(
   parameter int DATA_W = MAC_DATA_W,
   parameter int KEEP_W = DATA_W / 8,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              cancel_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [KEEP_W-1:0] keep_i,
   input  logic              crc_err_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [KEEP_W-1:0] keep_o,
   output logic              last_o,
   output logic              drop_o
`ifdef MAC_RX_FRAME_FIFO_STATS_EN
   ,
   output logic [CNT_W-1:0]  good_cnt_o,
   output logic [CNT_W-1:0]  crc_drop_cnt_o,
   output logic [CNT_W-1:0]  cancel_drop_cnt_o,
   output logic [CNT_W-1:0]  ovf_drop_cnt_o
`endif
);

   localparam int PTR_W = ADDR_W + 1;
   localparam int ENT_W = DATA_W + KEEP_W + 1;

   wr_state_e         state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [DATA_W-1:0] hold_data_q;
   logic [KEEP_W-1:0] hold_keep_q;
   logic              drop_q;

   logic              hold_en;
   logic              wr_en;
   logic              wr_last;
   logic              full;
   logic              drop_d;
   logic              ev_good, ev_crc, ev_cancel, ev_ovf;
   logic              rd_fire;
   logic [ENT_W-1:0]  rd_word;
   entry_t            rd_entry;

   // Occupancy counts everything written, committed or not, against the
   // pre-edge read pointer.
   assign full = ((wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH));

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      hold_en      = 1'b0;
      wr_en        = 1'b0;
      wr_last      = 1'b0;
      ev_good      = 1'b0;
      ev_crc       = 1'b0;
      ev_cancel    = 1'b0;
      ev_ovf       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               if (cancel_i) begin
                  state_d = ST_DISCARD;
               end else begin
                  state_d = ST_RECV;
                  hold_en = 1'b1;
               end
            end
         end
         ST_RECV: begin
            if (valid_i) begin
               if (cancel_i) begin
                  ev_cancel = 1'b1;
                  state_d   = ST_DISCARD;
               end else if (full) begin
                  ev_ovf  = 1'b1;
                  state_d = ST_DISCARD;
               end else begin
                  wr_en    = 1'b1;
                  hold_en  = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end else begin
               // End cycle: the held beat is the last one of the frame.
               state_d = ST_IDLE;
               if (cancel_i) begin
                  ev_cancel = 1'b1;
               end else if (crc_err_i) begin
                  ev_crc = 1'b1;
               end else if (full) begin
                  ev_ovf = 1'b1;
               end else begin
                  wr_en    = 1'b1;
                  wr_last  = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  ev_good  = 1'b1;
               end
            end
         end
         ST_DISCARD: begin
            if (!valid_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      drop_d = ev_crc | ev_cancel | ev_ovf;
      // Rewinding to commit_ptr throws away only the in-flight frame.
      if (drop_d) begin
         wr_ptr_d = commit_ptr_q;
      end
      if (ev_good) begin
         commit_ptr_d = wr_ptr_q + 1'b1;
      end
   end

   assign rd_fire = valid_o & ready_i;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         hold_data_q  <= '0;
         hold_keep_q  <= '0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         drop_q       <= drop_d;
         if (hold_en) begin
            hold_data_q <= data_i;
            hold_keep_q <= keep_i;
         end
         if (rd_fire) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   mac_rx_frame_ram #(
      .DEPTH  (DEPTH),
      .WIDTH  (ENT_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q[ADDR_W-1:0]),
      .wr_data ({hold_data_q, hold_keep_q, wr_last}),
      .rd_addr (rd_ptr_q[ADDR_W-1:0]),
      .rd_data (rd_word)
   );

   // Outputs are forced to zero when nothing is presented, which also gives
   // clean zeros during reset without resetting the array.
   assign rd_entry = rd_word;
   assign valid_o  = (rd_ptr_q != commit_ptr_q);
   assign data_o   = valid_o ? rd_entry.data : '0;
   assign keep_o   = valid_o ? rd_entry.keep : '0;
   assign last_o   = valid_o & rd_entry.last;
   assign drop_o   = drop_q;

`ifdef MAC_RX_FRAME_FIFO_STATS_EN
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         good_cnt_o        <= '0;
         crc_drop_cnt_o    <= '0;
         cancel_drop_cnt_o <= '0;
         ovf_drop_cnt_o    <= '0;
      end else begin
         if (ev_good)   good_cnt_o        <= sat_inc(good_cnt_o);
         if (ev_crc)    crc_drop_cnt_o    <= sat_inc(crc_drop_cnt_o);
         if (ev_cancel) cancel_drop_cnt_o <= sat_inc(cancel_drop_cnt_o);
         if (ev_ovf)    ovf_drop_cnt_o    <= sat_inc(ovf_drop_cnt_o);
      end
   end
`endif

endmodule

// File: tb/tb_mac_rx_frame_fifo.sv
// tb/tb_mac_rx_frame_fifo.sv - self-checking bench for mac_rx_frame_fifo
module tb_mac_rx_frame_fifo;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        cancel_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [15:0] data_i = '0;
   logic [1:0]  keep_i = '0;
   logic        crc_err_i = 1'b0;
   logic        ready_i = 1'b0;
   logic        valid_o;
   logic [15:0] data_o;
   logic [1:0]  keep_o;
   logic        last_o;
   logic        drop_o;
`ifdef MAC_RX_FRAME_FIFO_STATS_EN
   logic [15:0] good_cnt_o, crc_drop_cnt_o, cancel_drop_cnt_o, ovf_drop_cnt_o;
`endif

   mac_rx_frame_fifo dut (
      .clk       (clk),
      .nreset    (nreset),
      .cancel_i  (cancel_i),
      .valid_i   (valid_i),
      .data_i    (data_i),
      .keep_i    (keep_i),
      .crc_err_i (crc_err_i),
      .ready_i   (ready_i),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .keep_o    (keep_o),
      .last_o    (last_o),
      .drop_o    (drop_o)
`ifdef MAC_RX_FRAME_FIFO_STATS_EN
      ,
      .good_cnt_o        (good_cnt_o),
      .crc_drop_cnt_o    (crc_drop_cnt_o),
      .cancel_drop_cnt_o (cancel_drop_cnt_o),
      .ovf_drop_cnt_o    (ovf_drop_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: a queue of beats that downstream must see, in order.
   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  k;
      logic        l;
   } beat_t;

   beat_t       exp_q[$];
   int          exp_drops = 0;
   int          seen_drops = 0;
   logic [15:0] fd [0:127];
   logic [1:0]  fk [0:127];

   int   ready_mode = 0;   // 0 constant ready_val, 1 toggle, 2 random
   logic ready_val = 1'b1;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       ready_i = ready_val;
         1:       ready_i = ~ready_i;
         default: ready_i = 1'($urandom_range(0, 1));
      endcase
   end

   logic        prev_stall = 1'b0;
   logic [15:0] prev_d = '0;

   always @(negedge clk) begin
      if (nreset) begin
         if (drop_o) seen_drops++;
         if (prev_stall) begin
            check("stable_valid", valid_o, 1);
            check("stable_data", data_o, prev_d);
         end
         if (valid_o) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", valid_o, 0);
            end else begin
               check("out_data", data_o, exp_q[0].d);
               check("out_keep", keep_o, exp_q[0].k);
               check("out_last", last_o, exp_q[0].l);
               if (ready_i) void'(exp_q.pop_front());
            end
         end
         prev_stall = valid_o && !ready_i;
         prev_d     = data_o;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Frame fate from the rules: cancel with the first beat is silent,
   // cancel later or a CRC error drops, too big for the free space drops.
   task automatic model_frame(input int len, input bit crc, input int cancel_at, input int free);
      if (cancel_at == 0) begin
      end else if (cancel_at > 0 && cancel_at <= len) begin
         exp_drops++;
      end else if (crc) begin
         exp_drops++;
      end else if (len > free) begin
         exp_drops++;
      end else begin
         for (int i = 0; i < len; i++) exp_q.push_back('{fd[i], fk[i], (i == len - 1)});
      end
   endtask

   // Drives len beats then the end cycle; cancel_at == len cancels in the end cycle.
   task automatic send_frame(input int len, input bit crc, input int cancel_at);
      int free;
      free = DEPTH - exp_q.size();
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         valid_i   = 1'b1;
         data_i    = fd[i];
         keep_i    = fk[i];
         cancel_i  = (i == cancel_at);
         crc_err_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      valid_i   = 1'b0;
      data_i    = 16'($urandom);
      keep_i    = 2'($urandom);
      cancel_i  = (cancel_at == len);
      crc_err_i = crc;
      model_frame(len, crc, cancel_at, free);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         valid_i   = 1'b0;
         cancel_i  = 1'b0;
         crc_err_i = 1'b0;
      end
   endtask

   task automatic fill_random(input int len);
      for (int i = 0; i < len; i++) begin
         fd[i] = 16'($urandom);
         fk[i] = 2'($urandom_range(1, 3));
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      idle(2);
      ready_mode = 0;
      ready_val  = 1'b1;
      while ((exp_q.size() != 0 || valid_o) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      idle(1);
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_valid_low"}, valid_o, 0);
      check({tag, "_drops"}, seen_drops, exp_drops);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
      $fatal(1);
   end

   initial begin
      int len, gap, n;
      int cancel_at;
      bit crc;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", valid_o, 0);
      check("rst_data", data_o, 0);
      check("rst_keep", keep_o, 0);
      check("rst_last", last_o, 0);
      check("rst_drop", drop_o, 0);
      nreset = 1'b1;
      idle(2);

      // Good 3-beat frame and its latency.
      fd[0] = 16'haa55; fd[1] = 16'h1234; fd[2] = 16'hbeef;
      fk[0] = 2'b11;    fk[1] = 2'b11;    fk[2] = 2'b11;
      send_frame(3, 1'b0, -1);
      @(negedge clk);
      check("lat_end_cycle_valid", valid_o, 0);
      @(posedge clk); #1;
      check("lat_e1_valid", valid_o, 1);
      check("lat_e1_data", data_o, 16'haa55);
      drain("good");

      // CRC drop, then a single-beat frame.
      send_frame(3, 1'b1, -1);
      idle(3);
      check("crc_no_valid", valid_o, 0);
      fd[0] = 16'h0f0f; fk[0] = 2'b01;
      send_frame(1, 1'b0, -1);
      drain("crc");

      // Cancel on beat 2 of 4, then a normal frame.
      fill_random(4);
      send_frame(4, 1'b0, 1);
      idle(3);
      check("cancel_no_valid", valid_o, 0);
      fill_random(2);
      send_frame(2, 1'b0, -1);
      drain("cancel");

      // Overflow with downstream stalled, then an exact-fit frame.
      ready_mode = 0;
      ready_val  = 1'b0;
      idle(2);
      fill_random(70);
      send_frame(70, 1'b0, -1);
      idle(3);
      check("ovf_drops", seen_drops, exp_drops);
      check("ovf_no_valid", valid_o, 0);
      fill_random(64);
      send_frame(64, 1'b0, -1);
      idle(3);
      check("fit_valid", valid_o, 1);
      check("fit_first", data_o, fd[0]);
      drain("ovf");

      // Back-to-back 2-beat frames under alternating ready.
      ready_mode = 1;
      fill_random(2);
      send_frame(2, 1'b0, -1);
      send_frame(2, 1'b0, -1);
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("b2b_done_in_time", exp_q.size(), 0);
      drain("b2b");

      // Randomized frames with random ready.
      for (int f = 0; f < 80; f++) begin
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 24) : $urandom_range(1, 8);
         crc = ($urandom_range(0, 4) == 0);
         cancel_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
         ready_mode = 2;
         n = 0;
         while (exp_q.size() + len > DEPTH && n < 500) begin
            idle(1);
            n++;
         end
         if (n == 500) check("rand_space_wait", exp_q.size() + len, DEPTH);
         fill_random(len);
         send_frame(len, crc, cancel_at);
         gap = $urandom_range(0, 2);
         if (gap > 0) idle(gap);
      end
      drain("rand");

      // Reset in the middle of a frame with a committed frame waiting.
      ready_mode = 0;
      ready_val  = 1'b0;
      fill_random(2);
      send_frame(2, 1'b0, -1);
      idle(2);
      check("prerst_valid", valid_o, 1);
      @(posedge clk); #1;
      valid_i = 1'b1; data_i = 16'h1111; keep_i = 2'b11;
      @(posedge clk); #1;
      data_i = 16'h2222;
      #2;
      nreset = 1'b0;
      #1;
      check("midrst_valid", valid_o, 0);
      check("midrst_data", data_o, 0);
      check("midrst_keep", keep_o, 0);
      check("midrst_last", last_o, 0);
      check("midrst_drop", drop_o, 0);
      exp_q.delete();
      valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nreset = 1'b1;
      ready_val = 1'b1;
      idle(3);
      check("postrst_empty", valid_o, 0);
      fill_random(3);
      send_frame(3, 1'b0, -1);
      drain("postrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_rx_frame_fifo.md
Name: mac_rx_frame_fifo

Overview:
- Store-and-forward frame buffer directly downstream of mac_rx.
- Accepts the MAC receive beat stream and holds each frame until its end is seen with a good CRC; only then is the frame released on a ready/valid output with a last marker.
- Frames ending with crc_err_i, aborted by cancel_i, or exceeding buffer capacity are discarded entirely; downstream never sees a partial frame.

Parameters:
- DATA_W, 16, beat width in bits; matches mac_rx.
- KEEP_W, DATA_W/8, byte-enable width.
- DEPTH, 64, buffer entries; power of two, >= 4.
- ADDR_W, $clog2(DEPTH), entry address width; pointers are ADDR_W+1 bits.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- cancel_i  in  1  abort the in-flight frame (mac_rx cancel_o).
- valid_i  in  1  beat valid; high contiguously for the duration of a frame.
- data_i  in  DATA_W  beat data.
- keep_i  in  KEEP_W  byte enables of the beat.
- crc_err_i  in  1  CRC verdict, sampled only in the end cycle.
- ready_i  in  1  downstream ready.
- valid_o  out  1  output beat valid.
- data_o  out  DATA_W  output beat data.
- keep_o  out  KEEP_W  output byte enables.
- last_o  out  1  final beat of a frame.
- drop_o  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset values: valid_o=0, last_o=0, drop_o=0, data_o=0, keep_o=0. All pointers are 0 and the write FSM is in IDLE. Reset mid-frame discards buffered and in-flight data.
- End cycle: the first cycle with valid_i=0 after one or more valid beats.
- Hold register:
  - Each incoming beat is captured into a one-beat hold register.
  - When the next beat arrives, the previously held beat is written at wr_ptr with last=0.
  - In the end cycle, the held beat is written with last=1.
  - A single-beat frame is therefore supported.
- Write FSM states:
  - IDLE: valid_i & !cancel_i -> RECV, beat held. valid_i & cancel_i -> DISCARD. cancel_i alone is ignored.
  - RECV:
    - valid_i & !cancel_i & !full: flush the held beat and hold the new beat.
    - end cycle & !crc_err_i & !cancel_i: write the held beat with last=1. commit_ptr <= wr_ptr+1. -> IDLE.
    - end cycle & (crc_err_i | cancel_i): wr_ptr <= commit_ptr, drop_o pulse. -> IDLE.
    - cancel_i while valid_i: wr_ptr <= commit_ptr, drop_o pulse. -> DISCARD.
    - A flush needed while full (wr_ptr-rd_ptr == DEPTH): wr_ptr <= commit_ptr, drop_o pulse. -> DISCARD.
  - DISCARD: ignore all input until valid_i=0. -> IDLE with no second drop_o pulse. crc_err_i is ignored.
- Rewind never moves wr_ptr below commit_ptr; committed frames are never corrupted.
- Read side:
  - valid_o = (rd_ptr != commit_ptr).
  - data_o, keep_o and last_o come from the entry at rd_ptr.
  - rd_ptr increments on valid_o & ready_i.
  - Output must stay stable while valid_o & !ready_i.
- Latency: a good frame ending in cycle E has valid_o high in cycle E+1, with its first beat presented.
- Capacity: a frame needs at most DEPTH beats. A frame larger than the free space at its start is dropped.
- Simultaneous events:
  - A read and a write in the same cycle are both performed, and fullness uses the pre-edge rd_ptr.
  - Commit and read in the same cycle are both performed.
  - The cycle following an end cycle may start a new frame (back-to-back frames with a one-cycle gap).

Optional Feature:
- Macro: MAC_RX_FRAME_FIFO_STATS_EN.
- Defined: adds outputs good_cnt_o, crc_drop_cnt_o, cancel_drop_cnt_o and ovf_drop_cnt_o.
  - Each is 16 bits, saturates at 16'hffff and resets to 0.
  - Each increments once per frame at the same edge as commit or drop.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package mac_pkg holds:
  - the write FSM state enum (IDLE, RECV, DISCARD);
  - the entry struct {data, keep, last};
  - the counter width constant.
- One sub-module: mac_rx_frame_ram, a DEPTH x (DATA_W+KEEP_W+1) flop array with synchronous write port and asynchronous read port.

Test Plan:
- Good frame: 3 beats 16'haa55, 16'h1234, 16'hbeef, keep=2'b11, crc_err_i=0 at end, ready_i=1 -> starting the cycle after the end cycle, the same 3 beats are output on consecutive cycles; last_o=1 only on 16'hbeef; drop_o never asserts.
- CRC drop: the same 3 beats with crc_err_i=1 at end -> valid_o stays 0, drop_o pulses once. A following good 1-beat frame 16'h0f0f with keep=2'b01 is output alone with last_o=1.
- Cancel: cancel_i asserted on beat 2 of 4, valid_i stays high through beat 4 -> one drop_o pulse and no output. A next frame is accepted normally.
- Overflow: DEPTH=64, ready_i=0, a 70-beat frame -> drop_o pulses once and valid_o stays 0. A 64-beat frame then fills the buffer exactly and is released intact after ready_i=1.
- Backpressure and back-to-back: two 2-beat frames separated by a one-cycle gap, ready_i toggling 1010... -> data_o is held stable while stalled, 4 beats are output in order, and last_o is on beats 2 and 4.
- Reset mid-frame: nreset deasserted during beat 2 -> all outputs are 0 immediately, and after release the buffer is empty.
